// File: rtl/std_cache_pkg.sv
// Shared cache-line layout helpers: line / byte-enable widths and set-count derivation.
// Line layout (MSB..LSB): tag, data, valid, dirty. Byte-enable layout: tag, data, vldrty.
package std_cache_pkg;

  localparam int unsigned DEF_TAG_WIDTH  = 44;
  localparam int unsigned DEF_LINE_WIDTH = 128;

  function automatic int unsigned line_bits(input int unsigned tag_w, input int unsigned line_w);
    return tag_w + line_w + 2;
  endfunction

  function automatic int unsigned be_bits(input int unsigned tag_w, input int unsigned line_w);
    return (tag_w + 7) / 8 + line_w / 8 + 1;
  endfunction

  function automatic int unsigned num_sets(input int unsigned index_w, input int unsigned offset_w);
    return 1 << (index_w - offset_w);
  endfunction

  typedef struct packed {
    logic [DEF_TAG_WIDTH-1:0]  tag;
    logic [DEF_LINE_WIDTH-1:0] data;
    logic                      valid;
    logic                      dirty;
  } cache_line_t;

  typedef struct packed {
    logic [(DEF_TAG_WIDTH+7)/8-1:0] tag;
    logic [DEF_LINE_WIDTH/8-1:0]    data;
    logic                           vldrty;
  } cl_be_t;

endpackage

// File: rtl/rr_arb_prio.sv
// Round-robin arbiter over N requesters with a fixed-priority override that wins
// outright and leaves the rotation pointer untouched.
module rr_arb_prio #(
  parameter int unsigned N = 3,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_prio,
  input  logic [N-1:0]     i_req,
  output logic             o_prio_gnt,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_any
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_idx;
  logic [SUM_W-1:0] w_sum;
  logic             w_found;
  logic             w_rr_fire;

  // First requester at or after the pointer, wrapping at N
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_sum   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_sum = {1'b0, r_ptr} + SUM_W'(k);
      if (w_sum >= SUM_W'(N)) w_sum = w_sum - SUM_W'(N);
      if (!w_found && i_req[w_sum[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_sum[IDX_W-1:0];
      end
    end
  end

  assign w_rr_fire  = i_en & ~i_prio & w_found;
  assign o_prio_gnt = i_en & i_prio;
  assign o_gnt      = w_rr_fire ? (N'(1) << w_idx) : '0;
  assign o_gnt_idx  = w_idx;
  assign o_any      = i_en & (i_prio | w_found);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_rr_fire) begin
      r_ptr <= (w_idx == IDX_W'(N - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/tag_arb_rr.sv
// Tag-array front end: arbitrates cache ports onto the tag/data SRAM, checks tag hits
// one cycle later, and sweeps every set's valid/dirty bits clear after reset or on request.
module tag_arb_rr
  import std_cache_pkg::*;
#(
  parameter int unsigned NR_PORTS    = 4,
  parameter int unsigned SET_ASSOC   = 8,
  parameter int unsigned INDEX_WIDTH = 12,
  parameter int unsigned BYTE_OFFSET = 4,
  parameter int unsigned TAG_WIDTH   = 44,
  parameter int unsigned LINE_WIDTH  = 128,
  localparam int unsigned LINE_W = line_bits(TAG_WIDTH, LINE_WIDTH),
  localparam int unsigned BE_W   = be_bits(TAG_WIDTH, LINE_WIDTH)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  invalidate_i,
  input  logic [NR_PORTS-1:0][SET_ASSOC-1:0]    req_i,
  input  logic [NR_PORTS-1:0][INDEX_WIDTH-1:0]  addr_i,
  input  logic [NR_PORTS-1:0][TAG_WIDTH-1:0]    tag_i,
  input  logic [NR_PORTS-1:0]                   we_i,
  input  logic [NR_PORTS-1:0][LINE_W-1:0]       wdata_i,
  input  logic [NR_PORTS-1:0][BE_W-1:0]         be_i,
  output logic [NR_PORTS-1:0]                   gnt_o,
  output logic [SET_ASSOC-1:0][LINE_W-1:0]      rdata_o,
  output logic [SET_ASSOC-1:0]                  hit_way_o,
  output logic                                  multi_hit_o,
  output logic                                  sweep_busy_o,
  output logic [SET_ASSOC-1:0]                  req_o,
  output logic [INDEX_WIDTH-1:0]                addr_o,
  output logic                                  we_o,
  output logic [LINE_W-1:0]                     wdata_o,
  output logic [BE_W-1:0]                       be_o,
  input  logic [SET_ASSOC-1:0][LINE_W-1:0]      rdata_i
);

  localparam int unsigned SET_W     = INDEX_WIDTH - BYTE_OFFSET;
  localparam int unsigned NUM_SETS  = num_sets(INDEX_WIDTH, BYTE_OFFSET);
  localparam int unsigned ID_W      = $clog2(NR_PORTS);
  localparam int unsigned RR_N      = NR_PORTS - 1;
  localparam int unsigned RR_W      = (RR_N > 1) ? $clog2(RR_N) : 1;
  localparam int unsigned VALID_BIT = 1;

  if (NR_PORTS < 2 || SET_ASSOC == 0 || (SET_ASSOC & (SET_ASSOC - 1)) != 0 ||
      INDEX_WIDTH <= BYTE_OFFSET) begin : g_param_check
    $error("tag_arb_rr: illegal parameter combination");
  end

  typedef enum logic {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} state_e;

  state_e            r_state;
  logic [SET_W-1:0]  r_cnt;
  logic [ID_W-1:0]   r_id;
  logic              r_vld;

  logic [NR_PORTS-1:0] w_port_req;
  logic [RR_N-1:0]     w_rr_gnt;
  logic [RR_W-1:0]     w_rr_idx;
  logic                w_prio_gnt;
  logic                w_any;
  logic                w_idle;
  logic [ID_W-1:0]     w_gnt_id;

  always_comb begin
    for (int p = 0; p < NR_PORTS; p++) w_port_req[p] = |req_i[p];
  end

  assign w_idle = (r_state == ST_IDLE);

  rr_arb_prio #(.N(RR_N)) u_arb (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .i_en       (w_idle),
    .i_prio     (w_port_req[0]),
    .i_req      (w_port_req[NR_PORTS-1:1]),
    .o_prio_gnt (w_prio_gnt),
    .o_gnt      (w_rr_gnt),
    .o_gnt_idx  (w_rr_idx),
    .o_any      (w_any)
  );

  assign gnt_o        = {w_rr_gnt, w_prio_gnt};
  assign w_gnt_id     = w_prio_gnt ? '0 : ID_W'(w_rr_idx) + ID_W'(1);
  assign sweep_busy_o = (r_state == ST_SWEEP);
  assign rdata_o      = rdata_i;

  // SRAM port: sweep writes zero with only the valid/dirty enable; otherwise the granted port
  always_comb begin
    req_o   = '0;
    addr_o  = '0;
    we_o    = 1'b0;
    wdata_o = '0;
    be_o    = '0;
    if (r_state == ST_SWEEP) begin
      req_o   = '1;
      addr_o  = {r_cnt, BYTE_OFFSET'(0)};
      we_o    = 1'b1;
      be_o    = BE_W'(1);
    end else if (w_any) begin
      req_o   = req_i[w_gnt_id];
      addr_o  = addr_i[w_gnt_id];
      we_o    = we_i[w_gnt_id];
      wdata_o = wdata_i[w_gnt_id];
      be_o    = be_i[w_gnt_id];
    end
  end

  always_comb begin
    hit_way_o = '0;
    for (int w = 0; w < SET_ASSOC; w++) begin
      if (r_vld && rdata_i[w][VALID_BIT] && (rdata_i[w][LINE_W-1 -: TAG_WIDTH] == tag_i[r_id]))
        hit_way_o[w] = 1'b1;
    end
  end

  assign multi_hit_o = r_vld & (|(hit_way_o & (hit_way_o - SET_ASSOC'(1))));

  // A grant in the cycle invalidate is taken is not hit-checked: the sweep owns the next cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_SWEEP;
      r_cnt   <= '0;
      r_id    <= '0;
      r_vld   <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_vld <= w_any & ~invalidate_i;
      if (w_any) r_id <= w_gnt_id;
      if (invalidate_i) r_state <= ST_SWEEP;
    end else begin
      r_vld <= 1'b0;
      if (r_cnt == SET_W'(NUM_SETS - 1)) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tag_arb_rr.sv
// Self-checking bench for tag_arb_rr: directed sweep/arbitration/hit scenarios followed
// by randomized traffic against a behavioural arbitration and hit model.
module tb_tag_arb_rr;
  import std_cache_pkg::*;

  localparam int unsigned NP    = 4;
  localparam int unsigned SA    = 8;
  localparam int unsigned IW    = 6;
  localparam int unsigned BO    = 4;
  localparam int unsigned TW    = 44;
  localparam int unsigned LW    = 128;
  localparam int unsigned LNW   = line_bits(TW, LW);
  localparam int unsigned BEW   = be_bits(TW, LW);
  localparam int unsigned NSETS = num_sets(IW, BO);

  logic                      clk = 1'b0;
  logic                      rst_ni;
  logic                      invalidate_i;
  logic [NP-1:0][SA-1:0]     req_i;
  logic [NP-1:0][IW-1:0]     addr_i;
  logic [NP-1:0][TW-1:0]     tag_i;
  logic [NP-1:0]             we_i;
  logic [NP-1:0][LNW-1:0]    wdata_i;
  logic [NP-1:0][BEW-1:0]    be_i;
  logic [NP-1:0]             gnt_o;
  logic [SA-1:0][LNW-1:0]    rdata_o;
  logic [SA-1:0]             hit_way_o;
  logic                      multi_hit_o;
  logic                      sweep_busy_o;
  logic [SA-1:0]             req_o;
  logic [IW-1:0]             addr_o;
  logic                      we_o;
  logic [LNW-1:0]            wdata_o;
  logic [BEW-1:0]            be_o;
  logic [SA-1:0][LNW-1:0]    rdata_i;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tag_arb_rr #(
    .NR_PORTS(NP), .SET_ASSOC(SA), .INDEX_WIDTH(IW), .BYTE_OFFSET(BO),
    .TAG_WIDTH(TW), .LINE_WIDTH(LW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .invalidate_i(invalidate_i),
    .req_i(req_i), .addr_i(addr_i), .tag_i(tag_i), .we_i(we_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rdata_o(rdata_o),
    .hit_way_o(hit_way_o), .multi_hit_o(multi_hit_o), .sweep_busy_o(sweep_busy_o),
    .req_o(req_o), .addr_o(addr_o), .we_o(we_o), .wdata_o(wdata_o), .be_o(be_o),
    .rdata_i(rdata_i)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    invalidate_i = 1'b0;
    req_i = '0; addr_i = '0; tag_i = '0; we_i = '0;
    wdata_i = '0; be_i = '0; rdata_i = '0;
  endtask

  // Walks an active sweep; optionally pulses invalidate at sweep step pulse_at
  task automatic expect_sweep(input string name, input int pulse_at);
    int n;
    n = 0;
    while (sweep_busy_o === 1'b1 && n < int'(NSETS) + 4) begin
      invalidate_i = (n == pulse_at);
      #1;
      checks++;
      if (addr_o !== IW'(n << BO)) begin
        errors++;
        $display("FAIL %s sweep_addr[%0d]: got %h want %h", name, n, addr_o, IW'(n << BO));
      end
      checks++;
      if (req_o !== '1 || we_o !== 1'b1 || wdata_o !== '0 || be_o !== BEW'(1) || gnt_o !== '0) begin
        errors++;
        $display("FAIL %s sweep_ctl[%0d]: got req=%h we=%b be=%h gnt=%b wdata_zero=%b want req=ff we=1 be=%h gnt=0000 wdata_zero=1",
                 name, n, req_o, we_o, be_o, gnt_o, (wdata_o == '0), BEW'(1));
      end
      checks++;
      if (hit_way_o !== '0 || multi_hit_o !== 1'b0) begin
        errors++;
        $display("FAIL %s sweep_hit[%0d]: got hit=%h multi=%b want 00/0", name, n, hit_way_o, multi_hit_o);
      end
      n++;
      tick();
    end
    invalidate_i = 1'b0;
    checks++;
    if (n != int'(NSETS)) begin
      errors++;
      $display("FAIL %s sweep_len: got %0d cycles want %0d", name, n, NSETS);
    end
  endtask

  task automatic test_reset();
    cache_line_t cl;
    clear_inputs();
    req_i[0] = SA'(2);
    req_i[1] = SA'(1);
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (gnt_o !== '0 || hit_way_o !== '0 || multi_hit_o !== 1'b0 || sweep_busy_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b hit=%h multi=%b busy=%b want 0000/00/0/1",
               gnt_o, hit_way_o, multi_hit_o, sweep_busy_o);
    end
    @(posedge clk);
    #2;
    rst_ni = 1'b1;
    expect_sweep("reset", -1);
    cl = '0;
    cl.valid = 1'b1;
    rdata_i[0] = cl;
    #1;
    checks++;
    if (sweep_busy_o !== 1'b0 || hit_way_o !== '0) begin
      errors++;
      $display("FAIL first_idle: got busy=%b hit=%h want 0/00", sweep_busy_o, hit_way_o);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    int g;
    clear_inputs();
    for (int p = 1; p < int'(NP); p++) req_i[p] = SA'($urandom) | SA'(1);
    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < int'(NP); p++) addr_i[p] = IW'($urandom);
      g = 1 + (i % 3);
      #1;
      checks++;
      if (gnt_o !== (NP'(1) << g)) begin
        errors++;
        $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt_o, NP'(1) << g);
      end
      checks++;
      if (req_o !== req_i[g] || addr_o !== addr_i[g]) begin
        errors++;
        $display("FAIL rr_mux[%0d]: got req=%h addr=%h want req=%h addr=%h", i, req_o, addr_o, req_i[g], addr_i[g]);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_port0_prio();
    clear_inputs();
    for (int p = 0; p < int'(NP); p++) req_i[p] = SA'($urandom) | SA'(4);
    we_i[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wdata_i[0] = LNW'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      #1;
      checks++;
      if (gnt_o !== 4'b0001 || we_o !== 1'b1 || wdata_o !== wdata_i[0]) begin
        errors++;
        $display("FAIL prio_gnt[%0d]: got gnt=%b we=%b want gnt=0001 we=1", i, gnt_o, we_o);
      end
      tick();
    end
    req_i[0] = '0;
    #1;
    checks++;
    if (gnt_o !== 4'b0010) begin
      errors++;
      $display("FAIL prio_release: got %b want 0010", gnt_o);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_hit();
    cache_line_t cl;
    clear_inputs();
    req_i[2] = SA'(8);
    #1;
    checks++;
    if (gnt_o !== 4'b0100) begin
      errors++;
      $display("FAIL hit_gnt: got %b want 0100", gnt_o);
    end
    tick();
    tag_i[0] = TW'(44'h77);
    tag_i[1] = TW'(44'h66);
    tag_i[2] = TW'(44'h5A);
    tag_i[3] = TW'(44'h55);
    for (int w = 0; w < int'(SA); w++) begin
      cl = '0;
      cl.valid = 1'b1;
      cl.tag = TW'(44'h100 + w);
      cl.data = LW'({$urandom, $urandom, $urandom, $urandom});
      rdata_i[w] = cl;
    end
    cl = rdata_i[3]; cl.tag = TW'(44'h5A); rdata_i[3] = cl;
    cl = rdata_i[1]; cl.tag = TW'(44'h5A); cl.valid = 1'b0; rdata_i[1] = cl;
    cl = rdata_i[6]; cl.tag = TW'(44'h77); rdata_i[6] = cl;
    #1;
    checks++;
    if (hit_way_o !== 8'h08 || multi_hit_o !== 1'b0) begin
      errors++;
      $display("FAIL single_hit: got hit=%h multi=%b want 08/0", hit_way_o, multi_hit_o);
    end
    checks++;
    if (rdata_o !== rdata_i) begin
      errors++;
      $display("FAIL rdata_pass: got %h want %h", rdata_o[3], rdata_i[3]);
    end
    tick();
    req_i[2] = '0;
    cl = rdata_i[5]; cl.tag = TW'(44'h5A); rdata_i[5] = cl;
    #1;
    checks++;
    if (hit_way_o !== 8'h28 || multi_hit_o !== 1'b1) begin
      errors++;
      $display("FAIL multi_hit: got hit=%h multi=%b want 28/1", hit_way_o, multi_hit_o);
    end
    tick();
    #1;
    checks++;
    if (hit_way_o !== '0 || multi_hit_o !== 1'b0) begin
      errors++;
      $display("FAIL hit_no_vld: got hit=%h multi=%b want 00/0", hit_way_o, multi_hit_o);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_invalidate();
    cache_line_t cl;
    clear_inputs();
    req_i[1] = SA'(8'h10);
    invalidate_i = 1'b1;
    #1;
    checks++;
    if (gnt_o !== 4'b0010 || sweep_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL inv_gnt: got gnt=%b busy=%b want 0010/0", gnt_o, sweep_busy_o);
    end
    tick();
    invalidate_i = 1'b0;
    req_i[1] = '0;
    cl = '0;
    cl.valid = 1'b1;
    rdata_i[0] = cl;
    expect_sweep("invalidate", 2);
    clear_inputs();
  endtask

  task automatic test_reset_mid_sweep();
    clear_inputs();
    invalidate_i = 1'b1;
    tick();
    invalidate_i = 1'b0;
    tick();
    tick();
    #1;
    checks++;
    if (addr_o !== IW'(2 << BO) || sweep_busy_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_sweep_pos: got addr=%h busy=%b want %h/1", addr_o, sweep_busy_o, IW'(2 << BO));
    end
    req_i[0] = SA'(1);
    rst_ni = 1'b0;
    #1;
    checks++;
    if (gnt_o !== '0 || sweep_busy_o !== 1'b1 || addr_o !== '0) begin
      errors++;
      $display("FAIL mid_reset: got gnt=%b busy=%b addr=%h want 0000/1/00", gnt_o, sweep_busy_o, addr_o);
    end
    tick();
    rst_ni = 1'b1;
    expect_sweep("reset_mid", -1);
    clear_inputs();
  endtask

  task automatic test_random();
    int rr_next, m_id, g, p;
    bit m_vld;
    logic [NP-1:0] any, exp_gnt;
    logic [SA-1:0] exp_hit;
    logic exp_multi;
    bit mux_ok;
    cache_line_t cl;
    rr_next = 1; m_vld = 1'b0; m_id = 0;
    for (int it = 0; it < 80; it++) begin
      for (int q = 0; q < int'(NP); q++) begin
        if (q == 0) req_i[q] = ($urandom_range(0, 3) == 0) ? SA'($urandom) : '0;
        else        req_i[q] = ($urandom_range(0, 1) == 1) ? SA'($urandom) : '0;
        addr_i[q]  = IW'($urandom);
        tag_i[q]   = TW'({$urandom, $urandom});
        we_i[q]    = 1'($urandom);
        wdata_i[q] = LNW'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        be_i[q]    = BEW'($urandom);
        any[q]     = (req_i[q] != '0);
      end
      for (int w = 0; w < int'(SA); w++) begin
        cl.valid = 1'($urandom);
        cl.dirty = 1'($urandom);
        cl.data  = LW'({$urandom, $urandom, $urandom, $urandom});
        cl.tag   = (m_vld && $urandom_range(0, 2) == 0) ? tag_i[m_id] : TW'({$urandom, $urandom});
        rdata_i[w] = cl;
      end
      g = -1;
      if (any[0]) g = 0;
      else begin
        for (int k = 0; k < int'(NP) - 1; k++) begin
          p = 1 + ((rr_next - 1 + k) % (int'(NP) - 1));
          if (g < 0 && any[p]) g = p;
        end
      end
      exp_gnt = (g < 0) ? '0 : (NP'(1) << g);
      for (int w = 0; w < int'(SA); w++) begin
        cl = rdata_i[w];
        exp_hit[w] = m_vld && cl.valid && (cl.tag == tag_i[m_id]);
      end
      exp_multi = ($countones(exp_hit) > 1);
      #1;
      checks++;
      if (gnt_o !== exp_gnt) begin
        errors++;
        $display("FAIL rand_gnt[%0d]: got %b want %b", it, gnt_o, exp_gnt);
      end
      if (g >= 0) mux_ok = (req_o === req_i[g] && addr_o === addr_i[g] && we_o === we_i[g] &&
                            wdata_o === wdata_i[g] && be_o === be_i[g]);
      else        mux_ok = (req_o === '0 && addr_o === '0 && we_o === 1'b0 && wdata_o === '0 && be_o === '0);
      checks++;
      if (!mux_ok) begin
        errors++;
        $display("FAIL rand_mux[%0d]: got req=%h addr=%h we=%b be=%h for port %0d", it, req_o, addr_o, we_o, be_o, g);
      end
      checks++;
      if (hit_way_o !== exp_hit || multi_hit_o !== exp_multi) begin
        errors++;
        $display("FAIL rand_hit[%0d]: got hit=%h multi=%b want %h/%b", it, hit_way_o, multi_hit_o, exp_hit, exp_multi);
      end
      if (g > 0) rr_next = (g == int'(NP) - 1) ? 1 : g + 1;
      m_vld = (g >= 0);
      if (g >= 0) m_id = g;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_ni = 1'b0;
    test_reset();
    test_round_robin();
    test_port0_prio();
    test_hit();
    test_invalidate();
    test_reset_mid_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
